// File: rtl/ats_pkg.sv
// Shared time arithmetic and types for the ATS eligibility path.
// Comparisons are wrap-safe modulo 2^TS_WIDTH.
package ats_pkg;

  localparam int TS_WIDTH = 59;

  typedef logic [TS_WIDTH-1:0] timestamp_t;

  localparam timestamp_t MAX_RESIDENCE_PS_DEFAULT = 59'd1_000_000_000;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_HOLD,
    ST_PRESENT
  } gate_state_t;

  // True once now is at or past t; a negative modular difference means t is still ahead.
  function automatic logic ts_reached(timestamp_t now, timestamp_t t);
    timestamp_t diff;
    diff = now - t;
    return ~diff[TS_WIDTH-1];
  endfunction

  function automatic timestamp_t ts_ahead(timestamp_t now, timestamp_t t);
    return t - now;
  endfunction

endpackage

// File: rtl/ats_desc_fifo.sv
// In-order descriptor buffer; written data becomes readable on the cycle after the write.
module ats_desc_fifo #(
  parameter int WIDTH = 75,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_do;
  logic             rd_do;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign wr_do   = wr_en && !full;
  assign rd_do   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_do) wr_ptr <= wr_ptr + 1'b1;
      if (rd_do) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_do, rd_do})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_do) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ats_eligibility_gate.sv
// Holds ATS-stamped descriptors in order and releases the head once local time reaches it.
// state      | meaning
// EMPTY      | no head loaded; waiting for the buffer to fill
// HOLD       | head loaded, eligibility time not yet reached
// PRESENT    | head eligible, out_valid high until out_ready
import ats_pkg::*;

module ats_eligibility_gate #(
  parameter int                         TIMESTAMP_WIDTH  = TS_WIDTH,
  parameter int                         DESC_WIDTH       = 16,
  parameter int                         DEPTH            = 16,
  parameter logic [TIMESTAMP_WIDTH-1:0] MAX_RESIDENCE_PS = MAX_RESIDENCE_PS_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [TIMESTAMP_WIDTH-1:0] local_clock,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [TIMESTAMP_WIDTH-1:0] in_elig_time,
  input  logic [DESC_WIDTH-1:0]      in_desc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DESC_WIDTH-1:0]      out_desc,
  output logic [TIMESTAMP_WIDTH-1:0] out_elig_time,
  output logic                       drop_pulse,
  output logic [31:0]                drop_count,
  output logic [$clog2(DEPTH):0]     fill_level
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = TIMESTAMP_WIDTH + DESC_WIDTH;
  localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);

  gate_state_t                state;
  gate_state_t                state_nxt;
  logic [TIMESTAMP_WIDTH-1:0] ahead;
  logic                       too_far;
  logic                       accept;
  logic                       wr_en;
  logic                       rd_en;
  logic [EW-1:0]              rd_data;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [CW-1:0]              fifo_count;
  logic                       head_valid;
  logic                       ready_q;

  ats_desc_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data ({in_elig_time, in_desc}),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Occupancy counts the head register too, so full is judged on the total.
  assign head_valid = (state != ST_EMPTY);
  assign fill_level = fifo_count + {{(CW-1){1'b0}}, head_valid};
  assign in_ready   = ready_q && !fifo_full && (fill_level != FULL_LEVEL);
  assign out_valid  = (state == ST_PRESENT);

  assign ahead   = ts_ahead(local_clock, in_elig_time);
  assign too_far = (ahead > MAX_RESIDENCE_PS) && !ahead[TIMESTAMP_WIDTH-1];
  assign accept  = in_valid && in_ready;
  assign wr_en   = accept && !too_far;

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (!fifo_empty) begin
          rd_en     = 1'b1;
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (ts_reached(local_clock, out_elig_time)) state_nxt = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (out_ready) begin
          if (!fifo_empty) begin
            rd_en     = 1'b1;
            state_nxt = ST_HOLD;
          end else begin
            state_nxt = ST_EMPTY;
          end
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= ST_EMPTY;
      ready_q       <= 1'b0;
      out_desc      <= '0;
      out_elig_time <= '0;
      drop_pulse    <= 1'b0;
      drop_count    <= '0;
    end else begin
      state      <= state_nxt;
      ready_q    <= 1'b1;
      drop_pulse <= accept && too_far;
      if (rd_en) {out_elig_time, out_desc} <= rd_data;
      if (accept && too_far && (drop_count != 32'hFFFF_FFFF))
        drop_count <= drop_count + 32'd1;
    end
  end

endmodule

// File: doc/ats_eligibility_gate.md
Name: ats_eligibility_gate

Overview:
- Consumer of the free-running picosecond timestamp bus. Holds frame descriptors, each stamped with an ATS eligibility time, in an in-order buffer.
- Releases the head descriptor once the local clock reaches its eligibility time.
- Discards descriptors whose eligibility time lies more than MAX_RESIDENCE_PS beyond the current time.
- Sits between the per-flow ATS eligibility-time calculator and the egress queue arbiter of one shaper queue.

Parameters:
- TIMESTAMP_WIDTH, 59, width of local_clock and eligibility times, in ps.
- DESC_WIDTH, 16, opaque descriptor width (buffer address and length).
- DEPTH, 16, buffer entries; power of 2, at least 2.
- MAX_RESIDENCE_PS, 1000000000, admission limit in ps (1 ms); must be less than 2^(TIMESTAMP_WIDTH-2).

Ports:
- clk  in  1  single clock domain; local_clock is generated on the same clk.
- reset  in  1  synchronous, active-low; reset==0 at posedge clk resets the block.
- local_clock  in  TIMESTAMP_WIDTH  current time in ps, monotonic modulo 2^TIMESTAMP_WIDTH.
- in_valid  in  1  descriptor offered.
- in_ready  out  1  buffer can accept a descriptor.
- in_elig_time  in  TIMESTAMP_WIDTH  eligibility time of the offered descriptor.
- in_desc  in  DESC_WIDTH  offered descriptor.
- out_valid  out  1  head descriptor is eligible.
- out_ready  in  1  downstream accepts.
- out_desc  out  DESC_WIDTH  released descriptor.
- out_elig_time  out  TIMESTAMP_WIDTH  eligibility time of the released descriptor.
- drop_pulse  out  1  one-cycle pulse per discarded descriptor.
- drop_count  out  32  saturating discard counter.
- fill_level  out  $clog2(DEPTH)+1  stored entries, including the head register.

Behaviour:
- Reset values: in_ready=0 during reset and 1 in the first cycle after it. out_valid=0, out_desc=0, out_elig_time=0, drop_pulse=0, drop_count=0, fill_level=0. FSM is in EMPTY. Buffer pointers are cleared.
- Reset mid-operation: all stored and presented descriptors are lost silently; drop_count does not increment for them.
- Time arithmetic: all differences are taken modulo 2^W, where W=TIMESTAMP_WIDTH.
  - reached(t) = bit W-1 of (local_clock - t) is 0.
  - ahead(t) = (t - local_clock) mod 2^W.
  - This makes the comparison correct across the local_clock wrap to 0.
- in_ready = not full. It is computed from registered state only; a same-cycle pop does not raise it.
- Accept (in_valid && in_ready):
  - If ahead(in_elig_time) > MAX_RESIDENCE_PS and bit W-1 of ahead is 0 (too far in the future): discard. drop_pulse=1 in the next cycle; drop_count += 1, saturating at 0xFFFFFFFF.
  - Otherwise: write to the buffer tail.
  - Past eligibility times are admitted and release immediately.
- FSM, states EMPTY, HOLD, PRESENT:
  - EMPTY: on buffer non-empty, load head into the out_desc/out_elig_time registers, go to HOLD. The head appears at HOLD at the earliest 2 cycles after the accepting edge.
  - HOLD: each cycle evaluate reached(out_elig_time) with the current local_clock. When true, set out_valid=1 at that edge and go to PRESENT. out_valid is therefore visible one cycle after local_clock first satisfies the condition.
  - PRESENT: out_valid, out_desc and out_elig_time stay stable until out_ready. On handshake: clear out_valid; if the buffer is non-empty load the next head and go to HOLD, else go to EMPTY.
  - Minimum release spacing is 2 cycles (one bubble).
- Back-pressure: out_ready low has no effect on admission other than through full.
- fill_level: updated one cycle after each accept or handshake. Simultaneous accept and release leaves it unchanged.
- A discard never writes the buffer and never changes fill_level.

Decomposition:
- Shared package ats_pkg:
  - timestamp_t (TIMESTAMP_WIDTH bits).
  - Function ts_reached(now, t) and function ts_ahead(now, t), reused by the shaper calculator.
  - MAX_RESIDENCE_PS default.
  - FSM state enum.
- One sub-module: ats_desc_fifo, a synchronous FIFO of {elig_time, desc} with full/empty/count, no fall-through.

Test Plan:
- Basic release: local_clock starts at 1,000,000,000,000 and steps 8000/cycle. Push desc 0x0011 with elig = now + 80,000 → out_valid rises 11 cycles after the push. out_desc=0x0011, out_elig_time equals the pushed value.
- Ordering and spacing: push 3 descriptors with elig already past, out_ready=1 → releases in FIFO order at 2-cycle spacing. fill_level goes 3, 2, 1, 0.
- Residence drop: push elig = now + MAX_RESIDENCE_PS + 8000 → drop_pulse for exactly 1 cycle, drop_count=1, out_valid stays 0. Push elig = now + MAX_RESIDENCE_PS → stored, no drop.
- Wrap: local_clock = 2^59 − 16000, elig = 8000 (post-wrap) → no early release while local_clock is near 2^59−1. out_valid asserts only after local_clock ≥ 8000 following the wrap.
- Full and back-pressure: out_ready=0, push 17 eligible descriptors → in_ready=0 after 16, fill_level=16, 17th not accepted. Then out_ready=1 → in_ready returns the cycle after the first pop.
- Reset mid-operation: 5 entries stored and out_valid=1, assert reset (low) for 1 cycle → out_valid=0, fill_level=0, drop_count unchanged from 0, in_ready=1 the next cycle.
